// File: rtl/motion_pkg.sv
// Shared types and widths for the two-axis step sequencer.
// Imported by the sequencer top and its step timer.
package motion_pkg;

    localparam int POS_W = 32;
    localparam int CMD_W = 16;
    localparam int ERR_W = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STEP_HI,
        S_STEP_LO,
        S_DONE
    } state_t;

    // Magnitude of a signed command word; -32768 maps to 32768.
    function automatic logic [CMD_W-1:0] abs_cmd(input logic [CMD_W-1:0] v);
        return v[CMD_W-1] ? (~v + CMD_W'(1)) : v;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Down-counter for phase durations of the step sequencer.
// A load of N makes o_expire pulse in the N-th cycle after the load.
module step_timer
    import motion_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [CMD_W-1:0] i_count,
    output logic             o_expire
);

    logic [CMD_W-1:0] r_cnt;
    logic             r_active;

    // Count down the loaded duration; go inactive once it has expired.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_clear) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_cnt    <= i_count - CMD_W'(1);
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CMD_W'(1);
            end
        end
    end

    assign o_expire = r_active && (r_cnt == '0);

endmodule

// File: rtl/xy_step_sequencer.sv
// Two-axis STEP/DIR sequencer with Bresenham interpolation.
// One relative move per handshake; tracks signed absolute position.
module xy_step_sequencer
    import motion_pkg::*;
#(
    parameter int PULSE_W    = 50,
    parameter int MIN_PERIOD = 100,
    parameter int DIR_SETUP  = 25
)
(
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CMD_W-1:0] cmd_dx,
    input  logic [CMD_W-1:0] cmd_dy,
    input  logic [CMD_W-1:0] cmd_period,
    input  logic             abort,
    input  logic             zero_pos,
    output logic             step_x,
    output logic             step_y,
    output logic             dir_x,
    output logic             dir_y,
    output logic             drv_en,
    output logic             done,
    output logic             aborted,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y
);

    generate
        if (MIN_PERIOD <= PULSE_W) begin : g_bad_period
            $error("MIN_PERIOD must be larger than PULSE_W");
        end
        if (PULSE_W < 1 || DIR_SETUP < 1) begin : g_bad_width
            $error("PULSE_W and DIR_SETUP must be at least 1");
        end
    endgenerate

    localparam logic [CMD_W-1:0] LP_PULSE = CMD_W'(PULSE_W);
    localparam logic [CMD_W-1:0] LP_MINP  = CMD_W'(MIN_PERIOD);
    localparam logic [CMD_W-1:0] LP_SETUP = CMD_W'(DIR_SETUP);

    state_t           r_state;
    state_t           w_next;

    logic             r_dir_x;
    logic             r_dir_y;
    logic             r_x_major;
    logic [CMD_W-1:0] r_major;
    logic [CMD_W-1:0] r_minor;
    logic [CMD_W-1:0] r_eff_period;
    logic [CMD_W-1:0] r_ticks;
    logic [ERR_W-1:0] r_err;
    logic             r_tick_x;
    logic             r_tick_y;
    logic [POS_W-1:0] r_pos_x;
    logic [POS_W-1:0] r_pos_y;
    logic             r_aborted;

    logic [CMD_W-1:0] w_adx;
    logic [CMD_W-1:0] w_ady;
    logic             w_x_major;
    logic [CMD_W-1:0] w_major_in;
    logic [CMD_W-1:0] w_minor_in;
    logic [CMD_W-1:0] w_eff_in;
    logic             w_accept;
    logic             w_abort_hit;
    logic             w_expire;
    logic             w_more;
    logic             w_tick;
    logic [ERR_W-1:0] w_e;
    logic             w_minor_step;
    logic [ERR_W-1:0] w_err_nxt;
    logic             w_sx;
    logic             w_sy;
    logic [POS_W-1:0] w_dpx;
    logic [POS_W-1:0] w_dpy;
    logic             w_load;
    logic [CMD_W-1:0] w_load_val;

    assign w_adx       = abs_cmd(cmd_dx);
    assign w_ady       = abs_cmd(cmd_dy);
    assign w_x_major   = (w_adx >= w_ady);
    assign w_major_in  = w_x_major ? w_adx : w_ady;
    assign w_minor_in  = w_x_major ? w_ady : w_adx;
    assign w_eff_in    = (cmd_period < LP_MINP) ? LP_MINP : cmd_period;
    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    assign w_abort_hit = abort && (r_state != S_IDLE);
    assign w_more      = (r_ticks != r_major);

    // A major-axis tick happens on every entry into STEP_HI.
    assign w_tick = (w_next == S_STEP_HI) && (r_state != S_STEP_HI);

    assign w_e          = r_err + {1'b0, r_minor};
    assign w_minor_step = (w_e >= {1'b0, r_major});
    assign w_err_nxt    = w_minor_step ? (w_e - {1'b0, r_major}) : w_e;
    assign w_sx         = r_x_major | w_minor_step;
    assign w_sy         = ~r_x_major | w_minor_step;
    assign w_dpx        = r_dir_x ? POS_W'(1) : '1;
    assign w_dpy        = r_dir_y ? POS_W'(1) : '1;

    step_timer u_timer (
        .i_clk    (clk_clk),
        .i_rst_n  (reset_reset_n),
        .i_load   (w_load),
        .i_clear  (w_abort_hit),
        .i_count  (w_load_val),
        .o_expire (w_expire)
    );

    // State register.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        w_next = r_state;
        if (w_abort_hit) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        w_next = (w_major_in == '0) ? S_DONE : S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_expire) w_next = S_STEP_HI;
                end
                S_STEP_HI: begin
                    if (w_expire) w_next = S_STEP_LO;
                end
                S_STEP_LO: begin
                    if (w_expire) w_next = w_more ? S_STEP_HI : S_DONE;
                end
                S_DONE: begin
                    w_next = S_IDLE;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    // Load the phase timer with the duration of the phase being entered.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = LP_SETUP;
        if (w_next != r_state) begin
            unique case (w_next)
                S_SETUP: begin
                    w_load     = 1'b1;
                    w_load_val = LP_SETUP;
                end
                S_STEP_HI: begin
                    w_load     = 1'b1;
                    w_load_val = LP_PULSE;
                end
                S_STEP_LO: begin
                    w_load     = 1'b1;
                    w_load_val = r_eff_period - LP_PULSE;
                end
                default: begin
                    w_load = 1'b0;
                end
            endcase
        end
    end

    // Latch the move at accept and advance the Bresenham error per tick.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_dir_x      <= 1'b0;
            r_dir_y      <= 1'b0;
            r_x_major    <= 1'b1;
            r_major      <= '0;
            r_minor      <= '0;
            r_eff_period <= LP_MINP;
            r_ticks      <= '0;
            r_err        <= '0;
            r_tick_x     <= 1'b0;
            r_tick_y     <= 1'b0;
        end else if (w_accept) begin
            r_dir_x      <= ~cmd_dx[CMD_W-1];
            r_dir_y      <= ~cmd_dy[CMD_W-1];
            r_x_major    <= w_x_major;
            r_major      <= w_major_in;
            r_minor      <= w_minor_in;
            r_eff_period <= w_eff_in;
            r_ticks      <= '0;
            r_err        <= {1'b0, w_major_in >> 1};
            r_tick_x     <= 1'b0;
            r_tick_y     <= 1'b0;
        end else if (w_tick) begin
            r_ticks  <= r_ticks + CMD_W'(1);
            r_err    <= w_err_nxt;
            r_tick_x <= w_sx;
            r_tick_y <= w_sy;
        end
    end

    // Absolute position; a zero request discards a coincident step.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_pos_x <= '0;
            r_pos_y <= '0;
        end else if (zero_pos) begin
            r_pos_x <= '0;
            r_pos_y <= '0;
        end else if (w_tick) begin
            if (w_sx) r_pos_x <= r_pos_x + w_dpx;
            if (w_sy) r_pos_y <= r_pos_y + w_dpy;
        end
    end

    // One-cycle aborted pulse following an abort of an active move.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort_hit;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        drv_en    = (r_state == S_SETUP)
                 || (r_state == S_STEP_HI)
                 || (r_state == S_STEP_LO);
        done      = (r_state == S_DONE) && !abort;
        step_x    = (r_state == S_STEP_HI) && r_tick_x;
        step_y    = (r_state == S_STEP_HI) && r_tick_y;
    end

    assign dir_x   = r_dir_x;
    assign dir_y   = r_dir_y;
    assign aborted = r_aborted;
    assign pos_x   = r_pos_x;
    assign pos_y   = r_pos_y;

endmodule
